xor_cipher_serial: RTL and testbench
====================================

Name: xor_cipher_serial

Overview:
- Parametrised digit-serial XOR cipher for the crypto datapath, processing LANE_W bits per cycle over a DATA_W word.
- Adds valid/ready handshakes on both sides, encrypt/decrypt, and a chained mode in which each word is also XORed with the previous ciphertext, seeded by an IV.
- Sits between the word source and the output buffer; one word in flight at a time.

Parameters:
- DATA_W, 8, word/key/IV width in bits.
- LANE_W, 1, bits processed per PROC cycle. DATA_W % LANE_W != 0 is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word; 1 only in IDLE.
- in_first  in  1  word starts a new message; chain register loads iv.
- data_in  in  DATA_W  plaintext (encrypt) or ciphertext (decrypt).
- key  in  DATA_W  key; sampled with the word.
- iv  in  DATA_W  initial chain value; sampled only when in_first=1.
- mode  in  1  0 = plain XOR, 1 = chained; sampled with the word.
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled with the word.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- data_out  out  DATA_W  result word.
- busy  out  1  state is PROC or HOLD.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - out_valid=0, data_out=0, busy=0, and all internal registers (data, key, chain, counter) are cleared to 0.
  - in_ready=1 once in IDLE.
  - A reset mid-PROC or mid-HOLD discards the word and the chain state. No output handshake occurs.
- NL = DATA_W/LANE_W. The lane counter is max(1, clog2(NL)) bits wide.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture data_in, key, mode and decrypt.
  - If in_first=1, chain_reg <= iv.
  - Clear data_out and the counter, then go to PROC.
- PROC:
  - Lane i = lane_cnt occupies bits [i*LANE_W +: LANE_W].
  - Each cycle: data_out[lane] <= data_reg[lane] ^ key_reg[lane] ^ (mode ? chain_reg[lane] : 0).
  - On lane_cnt == NL-1, go to HOLD; otherwise increment the counter.
  - If NL=1, PROC lasts exactly one cycle.
- HOLD:
  - out_valid=1 and data_out is held stable until out_ready=1.
  - On out_valid & out_ready, update chain_reg, then go to IDLE:
    - encrypt: chain_reg <= data_out (the ciphertext just produced).
    - decrypt: chain_reg <= data_reg (the ciphertext just consumed).
- Symmetry: chained decrypt of a chained-encrypt stream, with the same key and IV, returns the plaintext.
- Latency:
  - Word accepted at edge k.
  - out_valid is high from edge k+NL until the output handshake edge.
  - in_ready rises on the cycle after the output handshake, so there is one idle cycle between words.
- Boundary conditions:
  - in_valid during PROC/HOLD is ignored (in_ready=0). The source must hold the word.
  - in_first=1 with mode=0: iv is still loaded; this has no effect on the output.
  - mode=0 words still update chain_reg on output.
  - out_ready high before HOLD has no effect.
  - Key and iv changes after acceptance have no effect.

Optional Feature:
- Macro: XOR_CIPHER_WCOUNT_EN.
- When defined:
  - Adds output word_cnt [15:0], reset to 0.
  - Set to 0 when a word with in_first=1 is accepted.
  - Increments by 1 on each output handshake; wraps 0xFFFF -> 0x0000.
  - If the clear and an increment fall on the same edge, the clear wins. This cannot occur, because in_ready=0 in HOLD.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- DATA_W=8, LANE_W=1, mode=0, encrypt, key=0x5A, data_in=0x3C, out_ready=1 -> out_valid rises 8 cycles after acceptance, data_out=0x66, then in_ready=1 again.
- Chained encrypt, key=0xFF, iv=0x0F: words 0x11 (in_first=1), then 0x22 -> outputs 0xE1, then 0x3C.
- Chained decrypt, key=0xFF, iv=0x0F: words 0xE1 (in_first=1), then 0x3C -> outputs 0x11, then 0x22.
- Backpressure, out_ready=0 for 5 cycles in HOLD -> out_valid=1 and data_out stable, in_ready=0, in_valid pulses ignored; result delivered on the first out_ready=1.
- DATA_W=16, LANE_W=4, mode=0, key=0xFFFF, data_in=0x1234 -> data_out=0xEDCB, 4 cycles after acceptance.
- Assert rst_n=0 on the 3rd PROC cycle -> out_valid=0, data_out=0, busy=0 immediately; the next chained word without in_first uses chain_reg=0. With XOR_CIPHER_WCOUNT_EN, word_cnt=0.

Source files
------------

// File: rtl/xor_cipher_serial.sv
// Digit-serial XOR cipher: LANE_W bits per cycle over a DATA_W word, plain or IV-seeded chained mode.
// Optional macro XOR_CIPHER_WCOUNT_EN adds a 16-bit delivered-word counter output (word_cnt).
module xor_cipher_serial #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANE_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_first,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] iv,
    input  logic              mode,
    input  logic              decrypt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
`ifdef XOR_CIPHER_WCOUNT_EN
    ,
    output logic [15:0]       word_cnt
`endif
);
    localparam int unsigned NL    = DATA_W / LANE_W;
    localparam int unsigned CNT_W = (NL > 1) ? $clog2(NL) : 1;

    if (DATA_W % LANE_W != 0) begin : g_bad_lane
        $error("DATA_W must be a multiple of LANE_W");
    end

    typedef enum logic [1:0] {StIdle, StProc, StHold} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] chain_q;
    logic              mode_q;
    logic              decrypt_q;
    logic [CNT_W-1:0]  lane_cnt_q;
    logic [LANE_W-1:0] lane_res;

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);

    always_comb begin
        lane_res = data_q[lane_cnt_q*LANE_W +: LANE_W] ^ key_q[lane_cnt_q*LANE_W +: LANE_W];
        if (mode_q) begin
            lane_res = lane_res ^ chain_q[lane_cnt_q*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            data_q     <= '0;
            key_q      <= '0;
            chain_q    <= '0;
            mode_q     <= 1'b0;
            decrypt_q  <= 1'b0;
            lane_cnt_q <= '0;
            out_valid  <= 1'b0;
            data_out   <= '0;
`ifdef XOR_CIPHER_WCOUNT_EN
            word_cnt   <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_q     <= data_in;
                        key_q      <= key;
                        mode_q     <= mode;
                        decrypt_q  <= decrypt;
                        if (in_first) begin
                            chain_q <= iv;
`ifdef XOR_CIPHER_WCOUNT_EN
                            word_cnt <= '0;
`endif
                        end
                        data_out   <= '0;
                        lane_cnt_q <= '0;
                        state_q    <= StProc;
                    end
                end
                StProc: begin
                    data_out[lane_cnt_q*LANE_W +: LANE_W] <= lane_res;
                    if (lane_cnt_q == CNT_W'(NL - 1)) begin
                        out_valid <= 1'b1;
                        state_q   <= StHold;
                    end else begin
                        lane_cnt_q <= lane_cnt_q + CNT_W'(1);
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        // Chain always follows the ciphertext side of the transform.
                        chain_q   <= decrypt_q ? data_q : data_out;
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
`ifdef XOR_CIPHER_WCOUNT_EN
                        word_cnt  <= word_cnt + 16'd1;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_xor_cipher_serial.sv
// Scoreboard bench for xor_cipher_serial: 8-bit serial instance plus a 16-bit/4-bit-lane instance.
`timescale 1ns/1ps
module tb_xor_cipher_serial;
    localparam int unsigned NL = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_first = 1'b0, mode = 1'b0, decrypt = 1'b0;
    logic [7:0] data_in = '0, key = '0, iv = '0;
    logic       in_ready, out_valid, busy;
    logic       out_ready = 1'b0;
    logic [7:0] data_out;
    int         rdy_mode = 1;

    logic        valid16 = 1'b0;
    logic [15:0] d16 = '0, k16 = '0;
    logic        in_ready16, ov16, busy16;
    logic [15:0] dout16;

`ifdef XOR_CIPHER_WCOUNT_EN
    logic [15:0] word_cnt, word_cnt16;
    int          m_wcnt = 0;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_chain = '0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    logic       after_hs = 1'b0;

    always #5 clk = ~clk;

    xor_cipher_serial #(.DATA_W(8), .LANE_W(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .data_in(data_in), .key(key), .iv(iv), .mode(mode),
        .decrypt(decrypt), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy)
`ifdef XOR_CIPHER_WCOUNT_EN
        , .word_cnt(word_cnt)
`endif
    );

    xor_cipher_serial #(.DATA_W(16), .LANE_W(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(valid16), .in_ready(in_ready16),
        .in_first(1'b1), .data_in(d16), .key(k16), .iv(16'h0), .mode(1'b0),
        .decrypt(1'b0), .out_valid(ov16), .out_ready(1'b1),
        .data_out(dout16), .busy(busy16)
`ifdef XOR_CIPHER_WCOUNT_EN
        , .word_cnt(word_cnt16)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 = hold low, 1 = hold high, otherwise random backpressure.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
            after_hs  = 1'b0;
        end else begin
            if (after_hs) begin
                chk("post_hs_in_ready", in_ready, 1);
                chk("post_hs_out_valid", out_valid, 0);
                chk("post_hs_busy", busy, 0);
`ifdef XOR_CIPHER_WCOUNT_EN
                chk("word_cnt", word_cnt, m_wcnt);
`endif
                after_hs = 1'b0;
            end
            if (out_valid) begin
                chk("hold_in_ready", in_ready, 0);
                chk("hold_busy", busy, 1);
                if (prev_hold) chk("hold_stable", data_out, prev_data);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        chk("data_out", data_out, exp_q.pop_front());
                    end
`ifdef XOR_CIPHER_WCOUNT_EN
                    m_wcnt = (m_wcnt + 1) % 65536;
`endif
                    after_hs  = 1'b1;
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                    prev_data = data_out;
                end
            end
        end
    end

    // Reference: result = d ^ k ^ (chained ? chain : 0); chain then follows the ciphertext.
    task automatic send(input logic [7:0] d, input logic [7:0] k, input logic [7:0] v,
                        input logic m, input logic dc, input logic f,
                        input bit use_exp, input logic [7:0] exp_v, input bit wait_out);
        logic [7:0] res;
        int         n;
        @(posedge clk);
        #2;
        data_in = d; key = k; iv = v; mode = m; decrypt = dc; in_first = f; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (f) m_chain = v;
        res     = d ^ k ^ (m ? m_chain : 8'h00);
        m_chain = dc ? d : res;
        exp_q.push_back(use_exp ? exp_v : res);
`ifdef XOR_CIPHER_WCOUNT_EN
        if (f) m_wcnt = 0;
`endif
        #1;
        in_valid = 1'b0;
        data_in = 8'($urandom); key = 8'($urandom); iv = 8'($urandom);
        mode = 1'($urandom); decrypt = 1'($urandom);
        if (wait_out) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!out_valid && n < 3 * NL);
            chk("latency", n, NL);
        end
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef XOR_CIPHER_WCOUNT_EN
        chk("rst_word_cnt", word_cnt, 0);
`endif
        rst_n = 1'b1;

        rdy_mode = 1;
        send(8'h3C, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1);
        send(8'h11, 8'hFF, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 8'hE1, 1'b1);
        send(8'h22, 8'hFF, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1);
        send(8'hE1, 8'hFF, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1);
        send(8'h3C, 8'hFF, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1);

        // Backpressure: stall in HOLD while the source pokes at in_valid.
        rdy_mode = 0;
        send(8'hA5, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 1'b1);
        repeat (5) begin
            in_valid = 1'b1; in_first = 1'b1; data_in = 8'($urandom);
            @(posedge clk);
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        rdy_mode = 1;
        n = 0;
        while (out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_release", out_valid, 0);
        chk("bp_no_extra", exp_q.size(), 0);

        // Reset on the third PROC cycle drops the word and the chain.
        send(8'h77, 8'h0F, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_data_out", data_out, 0);
        chk("mid_rst_busy", busy, 0);
`ifdef XOR_CIPHER_WCOUNT_EN
        chk("mid_rst_word_cnt", word_cnt, 0);
        m_wcnt = 0;
`endif
        exp_q.delete();
        m_chain = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h3C, 8'h5A, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1);

        rdy_mode = 2;
        repeat (40) begin
            send(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), 1'b0, 8'h00, 1'b1);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        rdy_mode = 1;

        // 16-bit word, 4-bit lanes.
        @(posedge clk);
        #1;
        chk("ready16", in_ready16, 1);
        d16 = 16'h1234; k16 = 16'hFFFF; valid16 = 1'b1;
        @(posedge clk);
        #1;
        valid16 = 1'b0; d16 = 16'h0000; k16 = 16'h0000;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ov16 && n < 12);
        chk("latency16", n, 4);
        chk("data16", dout16, 16'hEDCB);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
